// File: rtl/bram_fetch_arbiter_pkg.sv
// Shared definitions for the BRAM tile-fetch arbiter: FSM state encoding,
// requester names and the default BRAM region map.
package bram_fetch_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef enum int {
        REQ_W = 0,
        REQ_K = 1,
        REQ_V = 2
    } req_id_e;

    localparam int DEF_NUM_REQ    = 3;
    localparam int DEF_ADDR_WIDTH = 11;

    // Region bases: W at 0, K at 4, V at 772 (slice i is requester i).
    localparam logic [DEF_NUM_REQ*DEF_ADDR_WIDTH-1:0] DEF_BASE_ADDRS =
        {11'd772, 11'd4, 11'd0};

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bram_fetch_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after prio, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   prio,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    int   j;
    logic found;

    // Scan requesters starting at prio; the first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(prio) + k) % NUM_REQ;
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/bram_fetch_arbiter.sv
// Shares one BRAM read port among NUM_REQ tile fetchers. A granted requester
// gets NUM_FETCHES_PER_TILE consecutive reads from its region at its tile
// pointer; returning data is qualified by rd_valid/rd_last and done pulses
// with the last beat.
module bram_fetch_arbiter
    import bram_fetch_arbiter_pkg::*;
#(
    parameter int NUM_REQ              = 3,
    parameter int NUM_FETCHES_PER_TILE = 2,
    parameter int ADDR_WIDTH           = 11,
    parameter int PTR_WIDTH            = 9,
    parameter int RD_LATENCY           = 1,
    parameter logic [NUM_REQ*ADDR_WIDTH-1:0] BASE_ADDRS = DEF_BASE_ADDRS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    reset_ptr,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    done,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_en,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic                  busy
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int OFF_W = $clog2(NUM_FETCHES_PER_TILE + 1);
    localparam int LAT_W = $clog2(RD_LATENCY + 1);

    state_e                  state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]        gidx_q, gidx_d;
    logic [IDX_W-1:0]        prio_q, prio_d;
    logic [OFF_W-1:0]        off_q, off_d;
    logic [LAT_W-1:0]        wait_q, wait_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [PTR_WIDTH-1:0]    ptr_q [NUM_REQ];
    logic [PTR_WIDTH-1:0]    ptr_d [NUM_REQ];
    logic [RD_LATENCY-1:0]   vld_sr_q, vld_sr_d;
    logic [RD_LATENCY-1:0]   last_sr_q, last_sr_d;

    logic [NUM_REQ-1:0]      arb_gnt;
    logic [IDX_W-1:0]        arb_idx;
    logic [ADDR_WIDTH-1:0]   base_sel;
    logic [ADDR_WIDTH-1:0]   tile_base;
    logic                    fetch_last;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req     (req),
        .prio    (prio_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Outputs decode only from registered state, so req never reaches bram_en.
    assign bram_en   = (state_q == ST_FETCH);
    assign busy      = (state_q != ST_IDLE);
    assign grant     = grant_q;
    assign bram_addr = addr_q;
    assign rd_valid  = vld_sr_q[RD_LATENCY-1];
    assign rd_last   = last_sr_q[RD_LATENCY-1];
    assign done      = rd_last ? grant_q : '0;

    // Tile start address of the arbiter winner, truncated to the BRAM width.
    always_comb begin
        base_sel   = BASE_ADDRS[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        tile_base  = base_sel +
                     ADDR_WIDTH'(int'(ptr_q[arb_idx]) * NUM_FETCHES_PER_TILE);
        fetch_last = (off_q == OFF_W'(NUM_FETCHES_PER_TILE - 1));
    end

    // Next-state logic: FSM, offset and latency counters, pointers, read-return shift.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        prio_d  = prio_q;
        off_d   = off_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        ptr_d   = ptr_q;

        vld_sr_d     = vld_sr_q;
        last_sr_d    = last_sr_q;
        vld_sr_d[0]  = bram_en;
        last_sr_d[0] = bram_en & fetch_last;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_sr_d[i]  = vld_sr_q[i-1];
            last_sr_d[i] = last_sr_q[i-1];
        end

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_FETCH;
                    grant_d = arb_gnt;
                    gidx_d  = arb_idx;
                    off_d   = '0;
                    addr_d  = tile_base;
                end
            end
            ST_FETCH: begin
                if (fetch_last) begin
                    state_d = ST_WAIT;
                    wait_d  = LAT_W'(RD_LATENCY - 1);
                end else begin
                    off_d  = off_q + OFF_W'(1);
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            ST_WAIT: begin
                if (wait_q == '0) begin
                    state_d        = ST_IDLE;
                    grant_d        = '0;
                    prio_d         = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
                    ptr_d[gidx_q]  = ptr_q[gidx_q] + PTR_WIDTH'(1);
                end else begin
                    wait_d = wait_q - LAT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A pointer clear overrides a same-cycle completion increment.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset_ptr[i]) begin
                ptr_d[i] = '0;
            end
        end
    end

    // State registers; async reset drops the port and discards any tile in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            prio_q    <= '0;
            off_q     <= '0;
            wait_q    <= '0;
            addr_q    <= '0;
            vld_sr_q  <= '0;
            last_sr_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                ptr_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            prio_q    <= prio_d;
            off_q     <= off_d;
            wait_q    <= wait_d;
            addr_q    <= addr_d;
            vld_sr_q  <= vld_sr_d;
            last_sr_q <= last_sr_d;
            ptr_q     <= ptr_d;
        end
    end

endmodule

// File: tb/tb_bram_fetch_arbiter.sv
// Bench for bram_fetch_arbiter: default instance (N=2, latency 1) plus a
// second instance with N=4, latency 2. Expected behaviour comes from a
// tile-level model: winner, pointer and priority per tile, and a fixed
// per-cycle timeline relative to acceptance.
module tb_bram_fetch_arbiter;

    localparam int NA = 2;
    localparam int LA = 1;
    localparam int NB = 4;
    localparam int LB = 2;

    logic        clk;
    logic        rst_n;

    logic [2:0]  a_req, a_rp, a_grant, a_done;
    logic [10:0] a_addr;
    logic        a_en, a_vld, a_last, a_busy;

    logic [2:0]  b_req, b_rp, b_grant, b_done;
    logic [10:0] b_addr;
    logic        b_en, b_vld, b_last, b_busy;

    int n_cmp = 0;
    int n_err = 0;

    int m_ptr [3];
    int m_prio;

    bram_fetch_arbiter dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (a_req),
        .reset_ptr (a_rp),
        .grant     (a_grant),
        .done      (a_done),
        .bram_addr (a_addr),
        .bram_en   (a_en),
        .rd_valid  (a_vld),
        .rd_last   (a_last),
        .busy      (a_busy)
    );

    bram_fetch_arbiter #(
        .NUM_FETCHES_PER_TILE (NB),
        .RD_LATENCY           (LB)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (b_req),
        .reset_ptr (b_rp),
        .grant     (b_grant),
        .done      (b_done),
        .bram_addr (b_addr),
        .bram_en   (b_en),
        .rd_valid  (b_vld),
        .rd_last   (b_last),
        .busy      (b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int base_of(input int i);
        case (i)
            0:       return 0;
            1:       return 4;
            default: return 772;
        endcase
    endfunction

    function automatic int pick(input logic [2:0] r, input int prio);
        for (int k = 0; k < 3; k++) begin
            if (r[(prio + k) % 3]) return (prio + k) % 3;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_ptr[i] = 0;
        m_prio = 0;
    endtask

    // Assert reset, check outputs drop asynchronously, release on a negedge.
    task automatic apply_reset();
        logic [41:0] obs_v;
        a_req = '0; a_rp = '0; b_req = '0; b_rp = '0;
        rst_n = 1'b0;
        #1;
        obs_v = {a_en, a_grant, a_done, a_vld, a_last, a_busy, a_addr,
                 b_en, b_grant, b_done, b_vld, b_last, b_busy, b_addr};
        n_cmp++;
        if (obs_v !== 42'd0) begin
            n_err++;
            $display("FAIL reset_outputs got=%h exp=0", obs_v);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One tile on dut_a; entered and left just after a negedge in an IDLE cycle.
    task automatic do_tile(input string name, input logic [2:0] r,
                           input int drop_c, input logic [2:0] rp_done);
        int w;
        int base;
        logic [2:0]  g;
        logic [10:0] ea;
        logic [20:0] exp_v, obs_v;
        w    = pick(r, m_prio);
        g    = 3'b001 << w;
        base = base_of(w) + m_ptr[w] * NA;
        ea   = '0;
        a_req = r;
        @(posedge clk);
        for (int c = 1; c <= NA + LA; c++) begin
            @(negedge clk);
            ea    = 11'((base + ((c <= NA) ? c - 1 : NA - 1)) & 32'h7ff);
            exp_v = {(c <= NA), g, (c == NA + LA) ? g : 3'b000,
                     (c > LA), (c == NA + LA), 1'b1, ea};
            obs_v = {a_en, a_grant, a_done, a_vld, a_last, a_busy, a_addr};
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL %s cycle=%0d got=%h exp=%h (en,grant,done,vld,last,busy,addr)",
                         name, c, obs_v, exp_v);
            end
            if (c == drop_c) a_req = 3'b000;
            if (c == NA + LA) a_rp = rp_done;
        end
        m_ptr[w] = (m_ptr[w] + 1) % 512;
        for (int i = 0; i < 3; i++) if (rp_done[i]) m_ptr[i] = 0;
        m_prio = (w + 1) % 3;
        @(negedge clk);
        a_rp  = 3'b000;
        exp_v = {10'd0, ea};
        obs_v = {a_en, a_grant, a_done, a_vld, a_last, a_busy, a_addr};
        n_cmp++;
        if (obs_v !== exp_v) begin
            n_err++;
            $display("FAIL %s_idle got=%h exp=%h", name, obs_v, exp_v);
        end
    endtask

    task automatic pulse_rp_idle(input logic [2:0] mask);
        a_req = 3'b000;
        a_rp  = mask;
        @(negedge clk);
        a_rp  = 3'b000;
        for (int i = 0; i < 3; i++) if (mask[i]) m_ptr[i] = 0;
        n_cmp++;
        if (a_busy !== 1'b0) begin
            n_err++;
            $display("FAIL rp_idle_busy got=%b exp=0", a_busy);
        end
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        do_tile("single_w0", 3'b001, 0, 3'b000);
        do_tile("single_w1", 3'b001, 0, 3'b000);
    endtask

    task automatic test_all_three();
        apply_reset();
        do_tile("all_first",  3'b111, 0, 3'b000);
        do_tile("all_second", 3'b111, 0, 3'b000);
        do_tile("all_third",  3'b111, 0, 3'b000);
        do_tile("wrap_first",  3'b011, 0, 3'b000);
        do_tile("wrap_second", 3'b011, 0, 3'b000);
    endtask

    task automatic test_rp_collision();
        do_tile("rp_k_done", 3'b010, 0, 3'b010);
        do_tile("rp_k_next", 3'b010, 0, 3'b000);
    endtask

    task automatic test_drop_req();
        apply_reset();
        do_tile("drop_v",  3'b100, 1, 3'b000);
        do_tile("after_v", 3'b100, 0, 3'b000);
    endtask

    task automatic test_random();
        logic [2:0] r, rp;
        int drop;
        for (int it = 0; it < 40; it++) begin
            r    = 3'($urandom_range(1, 7));
            drop = $urandom_range(0, NA + LA);
            rp   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            do_tile("random", r, drop, rp);
            if ($urandom_range(0, 4) == 0) pulse_rp_idle(3'($urandom_range(1, 7)));
        end
        a_req = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_midtile_reset();
        a_req = 3'b001;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (a_en !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_pre_en got=%b exp=1", a_en);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_en, a_grant, a_busy, a_done, a_vld} !== 9'd0) begin
            n_err++;
            $display("FAIL midreset_async got=%b exp=0", {a_en, a_grant, a_busy, a_done, a_vld});
        end
        a_req = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({a_done, a_last, a_busy} !== 5'd0) begin
                n_err++;
                $display("FAIL midreset_no_done cycle=%0d got=%b exp=0", c, {a_done, a_last, a_busy});
            end
        end
        do_tile("post_reset_w", 3'b001, 0, 3'b000);
        do_tile("post_reset_k", 3'b010, 0, 3'b000);
        a_req = 3'b000;
    endtask

    task automatic test_long_latency();
        int ptr0;
        logic [10:0] ea;
        logic [20:0] exp_v, obs_v;
        apply_reset();
        ptr0  = 0;
        ea    = '0;
        b_req = 3'b001;
        for (int t = 0; t <= 512; t++) begin
            @(posedge clk);
            for (int c = 1; c <= NB + LB; c++) begin
                @(negedge clk);
                ea    = 11'((ptr0 * NB + ((c <= NB) ? c - 1 : NB - 1)) & 32'h7ff);
                exp_v = {(c <= NB), 3'b001, (c == NB + LB) ? 3'b001 : 3'b000,
                         (c > LB), (c == NB + LB), 1'b1, ea};
                obs_v = {b_en, b_grant, b_done, b_vld, b_last, b_busy, b_addr};
                n_cmp++;
                if (obs_v !== exp_v) begin
                    n_err++;
                    $display("FAIL long_lat tile=%0d cycle=%0d got=%h exp=%h", t, c, obs_v, exp_v);
                end
                if (t == 512 && c == 1) begin
                    n_cmp++;
                    if (b_addr !== 11'd0) begin
                        n_err++;
                        $display("FAIL ptr_wrap_addr got=%0d exp=0", b_addr);
                    end
                end
            end
            ptr0 = (ptr0 + 1) % 512;
            @(negedge clk);
            n_cmp++;
            if ({b_en, b_busy, b_vld, b_done} !== 6'd0) begin
                n_err++;
                $display("FAIL long_lat_idle tile=%0d got=%b exp=0", t, {b_en, b_busy, b_vld, b_done});
            end
        end
        b_req = 3'b000;
    endtask

    initial begin
        a_req = '0; a_rp = '0; b_req = '0; b_rp = '0;
        rst_n = 1'b1;
        model_reset();
        #2;
        test_reset();
        test_single();
        test_all_three();
        test_rp_collision();
        test_drop_req();
        test_random();
        test_midtile_reset();
        test_long_latency();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
